// File: rtl/uart_send.sv
// ---------------------------------------------------------------------------
// uart_send
//
// UART transmitter. Serialises one byte per request onto txd, LSB first.
// The default frame is 8N1: start bit, eight data bits, one stop bit.
//
// Optional feature (compile-time macro UART_TX_PARITY_EN):
//   When the macro is defined, a parity bit is sent between the last data bit
//   and the stop bit. Its value is (^data) ^ PARITY_ODD, so PARITY_ODD=0 gives
//   even parity and PARITY_ODD=1 gives odd parity. The frame is then 11 bits.
//   When the macro is not defined, the parity state and parity logic are absent.
//
// Parameters:
//   CLK_FREQ   - sys_clk frequency in Hz
//   UART_BPS   - baud rate; BPS_CNT = CLK_FREQ/UART_BPS clocks per bit (>= 4)
//   PARITY_ODD - parity sense (0 even, 1 odd); only used with UART_TX_PARITY_EN
//
// Ports:
//   sys_clk   in   system clock, rising edge
//   sys_rst   in   asynchronous active-high reset
//   sent_en   in   send request; only its rising edge starts a frame
//   send_data in   byte to send, captured when the frame starts
//   tx_busy   out  high while a frame is in flight
//   tx_done   out  one-cycle pulse after the last stop-bit clock
//   txd       out  serial line, idles high
// ---------------------------------------------------------------------------
module uart_send #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int UART_BPS   = 115200,
    parameter int PARITY_ODD = 0
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       sent_en,
    input  logic [7:0] send_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       txd
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int CNT_W   = $clog2(BPS_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Elaboration-time guard against bit periods too short for the counter
    // and against a parity sense other than 0/1.
    generate
        if (BPS_CNT < 4 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
            $error("uart_send: BPS_CNT must be >= 4 and PARITY_ODD must be 0 or 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg,   cnt_next;
    logic [2:0]       bit_reg,   bit_next;
    logic [7:0]       data_reg,  data_next;
    logic             txd_reg,   txd_next;
    logic             busy_reg,  busy_next;
    logic             done_reg,  done_next;
    logic             en_d0_reg, en_d1_reg;
    logic             en_flag;
    logic             cnt_last;

    // Two-stage request registers: a start is only recognised on a 0->1
    // transition, so a level held high sends exactly one frame.
    assign en_flag  = en_d0_reg & ~en_d1_reg;
    assign cnt_last = (cnt_reg == CNT_MAX);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            data_reg  <= '0;
            txd_reg   <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            en_d0_reg <= 1'b0;
            en_d1_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            data_reg  <= data_next;
            txd_reg   <= txd_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            en_d0_reg <= sent_en;
            en_d1_reg <= en_d0_reg;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        data_next  = data_reg;
        txd_next   = txd_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;

        // The bit-period counter runs in every active state; each state only
        // acts on the final count of its bit.
        if (state_reg != ST_IDLE && !cnt_last) begin
            cnt_next = cnt_reg + CNT_ONE;
        end

        case (state_reg)
            ST_IDLE: begin
                // Requests are only honoured here, so a request during a
                // frame (including its final stop cycle) is dropped.
                if (en_flag) begin
                    data_next  = send_data;
                    busy_next  = 1'b1;
                    txd_next   = 1'b0;
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (cnt_last) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    txd_next   = data_reg[0];
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_last) begin
                    cnt_next = '0;
                    if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        txd_next   = (^data_reg) ^ 1'(PARITY_ODD);
                        state_next = ST_PARITY;
`else
                        txd_next   = 1'b1;
                        state_next = ST_STOP;
`endif
                    end else begin
                        bit_next = bit_reg + 3'd1;
                        txd_next = data_reg[bit_reg + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (cnt_last) begin
                    cnt_next   = '0;
                    txd_next   = 1'b1;
                    state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_last) begin
                    cnt_next   = '0;
                    txd_next   = 1'b1;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                txd_next   = 1'b1;
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    assign txd     = txd_reg;
    assign tx_busy = busy_reg;
    assign tx_done = done_reg;

endmodule

// File: tb/tb_uart_send.sv
`timescale 1ns/1ps
module tb_uart_send;

    localparam int CLK_FREQ = 1_000_000;
    localparam int UART_BPS = 100_000;
    localparam int B        = 10;      // clocks per bit at these settings
    localparam int P_ODD    = 0;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS     = 11;
    localparam int EXP_BUSY  = 110;
`else
    localparam int NBITS     = 10;
    localparam int EXP_BUSY  = 100;
`endif

    logic       sys_clk;
    logic       sys_rst;
    logic       sent_en;
    logic [7:0] send_data;
    logic       tx_busy;
    logic       tx_done;
    logic       txd;

    uart_send #(
        .CLK_FREQ  (CLK_FREQ),
        .UART_BPS  (UART_BPS),
        .PARITY_ODD(P_ODD)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .sent_en  (sent_en),
        .send_data(send_data),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .txd      (txd)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    always @(posedge sys_clk) cyc++;

    task automatic check_bit(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A frame is described by the clock edge it started on and the byte it
    // carries; the expected line level is derived from elapsed time / B.
    logic       s1 = 1'b0, s2 = 1'b0;
    bit         m_active = 1'b0;
    int         m_edge = 0;
    int         m_start = 0;
    logic [7:0] m_data;

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s1 = 1'b0;
            s2 = 1'b0;
            m_active = 1'b0;
        end else begin
            m_edge++;
            if (s1 && !s2 && (!m_active || (m_edge - m_start) >= NBITS*B + 1)) begin
                m_active = 1'b1;
                m_start  = m_edge;
                m_data   = send_data;
            end
            s2 = s1;
            s1 = sent_en;
        end
    end

    task automatic model_out(output logic etxd, output logic ebusy, output logic edone);
        int e, k;
        etxd = 1'b1; ebusy = 1'b0; edone = 1'b0;
        if (m_active) begin
            e = m_edge - m_start;
            if (e < NBITS*B) begin
                ebusy = 1'b1;
                k = e / B;
                if (k == 0)
                    etxd = 1'b0;
                else if (k <= 8)
                    etxd = m_data[k-1];
`ifdef UART_TX_PARITY_EN
                else if (k == 9)
                    etxd = (^m_data) ^ 1'(P_ODD);
`endif
            end else if (e == NBITS*B) begin
                edone = 1'b1;
            end
        end
    endtask

    // Per-cycle comparison plus run-length monitors for busy/idle/done.
    int   busy_run = 0, idle_run = 0, last_busy = 0, last_idle = 0, done_cnt = 0;
    logic prev_busy = 1'b0;

    always @(negedge sys_clk) begin
        logic et, eb, ed;
        model_out(et, eb, ed);
        check_bit("txd", txd, et);
        check_bit("tx_busy", tx_busy, eb);
        check_bit("tx_done", tx_done, ed);
        if (tx_busy) begin
            if (!prev_busy) last_idle = idle_run;
            busy_run++;
            idle_run = 0;
        end else begin
            if (prev_busy) last_busy = busy_run;
            busy_run = 0;
            idle_run++;
        end
        if (tx_done) done_cnt++;
        prev_busy = tx_busy;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            #1;
        end
    endtask

    logic [7:0] a5_bits;
    int         d0;

    initial begin
        sys_rst   = 1'b1;
        sent_en   = 1'b0;
        send_data = 8'h00;
        tick(3);
        check_bit("reset_txd", txd, 1'b1);
        check_bit("reset_busy", tx_busy, 1'b0);
        check_bit("reset_done", tx_done, 1'b0);
        sys_rst = 1'b0;
        tick(2);

        // A5: start bit two edges after the request rises, then LSB-first data.
        d0 = done_cnt;
        a5_bits = 8'b1010_0101;   // LSB first: 1,0,1,0,0,1,0,1
        send_data = 8'hA5;
        sent_en = 1'b1;
        tick(1);
        check_bit("a5_not_yet", txd, 1'b1);
        sent_en = 1'b0;
        tick(1);
        check_bit("a5_start_txd", txd, 1'b0);
        check_bit("a5_start_busy", tx_busy, 1'b1);
        for (int k = 0; k < 8; k++) begin
            tick(B);
            check_bit($sformatf("a5_bit%0d", k), txd, a5_bits[k]);
        end
`ifdef UART_TX_PARITY_EN
        tick(B);
        check_bit("a5_parity", txd, (P_ODD == 0) ? 1'b0 : 1'b1);
`endif
        tick(B);
        check_bit("a5_stop", txd, 1'b1);
        tick(B);
        check_bit("a5_done", tx_done, 1'b1);
        check_bit("a5_idle", tx_busy, 1'b0);
        tick(3);
        check_int("a5_busy_len", last_busy, EXP_BUSY);
        check_int("a5_done_cnt", done_cnt - d0, 1);

        // 3C with sent_en held high: one frame only.
        d0 = done_cnt;
        send_data = 8'h3C;
        sent_en = 1'b1;
        tick(NBITS*B + 30);
        check_int("hold_done_cnt", done_cnt - d0, 1);
        check_bit("hold_txd_idle", txd, 1'b1);
        sent_en = 1'b0;
        tick(3);

        // 55 with a second request and new data during bit 3.
        d0 = done_cnt;
        send_data = 8'h55;
        sent_en = 1'b1;
        tick(2);
        sent_en = 1'b0;
        tick(42);
        sent_en = 1'b1;
        send_data = 8'hFF;
        tick(3);
        sent_en = 1'b0;
        tick(NBITS*B);
        check_int("busy_req_len", last_busy, EXP_BUSY);
        check_int("busy_req_done", done_cnt - d0, 1);
        check_bit("busy_req_idle", tx_busy, 1'b0);

        // 81 interrupted by reset during bit 4, then a clean 0F frame.
        send_data = 8'h81;
        sent_en = 1'b1;
        tick(2);
        sent_en = 1'b0;
        tick(53);
        sys_rst = 1'b1;
        #1;
        check_bit("rst_mid_txd", txd, 1'b1);
        check_bit("rst_mid_busy", tx_busy, 1'b0);
        tick(1);
        sys_rst = 1'b0;
        tick(3);
        d0 = done_cnt;
        send_data = 8'h0F;
        sent_en = 1'b1;
        tick(2);
        sent_en = 1'b0;
        tick(NBITS*B + 3);
        check_int("after_rst_len", last_busy, EXP_BUSY);
        check_int("after_rst_done", done_cnt - d0, 1);

        // 12 then 34, second request edge timed to be seen in the idle cycle.
        d0 = done_cnt;
        send_data = 8'h12;
        sent_en = 1'b1;
        tick(1);
        sent_en = 1'b0;
        tick(NBITS*B);
        send_data = 8'h34;
        sent_en = 1'b1;
        tick(1);
        check_bit("b2b_done", tx_done, 1'b1);
        check_bit("b2b_gap_txd", txd, 1'b1);
        sent_en = 1'b0;
        tick(1);
        check_bit("b2b_second_start", txd, 1'b0);
        check_int("b2b_gap_len", last_idle, 1);
        tick(NBITS*B + 3);
        check_int("b2b_done_cnt", done_cnt - d0, 2);

`ifdef UART_TX_PARITY_EN
        // 07 has three ones: even parity bit 1, odd parity bit 0.
        send_data = 8'h07;
        sent_en = 1'b1;
        tick(1);
        sent_en = 1'b0;
        tick(1);
        tick(9*B);
        check_bit("par07_bit", txd, (P_ODD == 0) ? 1'b1 : 1'b0);
        tick(2*B + 3);
        check_int("par07_len", last_busy, 110);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/uart_send.md
Name: uart_send

Overview:
- UART transmitter that serialises one byte per request onto a single txd line.
- Consumes the `sent_en`/`send_data` request from the loopback/command logic and reports `tx_busy` back to it.
- Frame format: 8N1 by default, LSB first, with an optional parity bit.
- Sits between the byte-level control logic and the board TX pin.

Parameters:
- CLK_FREQ, 50_000_000, sys_clk frequency in Hz.
- UART_BPS, 115200, baud rate. BPS_CNT = CLK_FREQ/UART_BPS uses integer division (434 at the defaults); BPS_CNT must be >= 4.
- PARITY_ODD, 0, parity sense: 0 = even, 1 = odd. Only used when UART_TX_PARITY_EN is defined.

Ports:
- sys_clk  input  1  system clock; all logic on the rising edge.
- sys_rst  input  1  asynchronous, active-high reset.
- sent_en  input  1  send request; a frame starts only on the rising edge of this signal (a held level has no further effect).
- send_data  input  8  byte to send; sampled on the same cycle the start is accepted.
- tx_busy  output  1  high while a frame is in flight.
- tx_done  output  1  single-cycle pulse after the last stop-bit cycle.
- txd  output  1  serial line; idles high.

Behaviour:
- Reset values (applied asynchronously on sys_rst):
  - txd=1, tx_busy=0, tx_done=0.
  - Baud counter=0, bit index=0, shift register=0, edge registers=0.
- Request edge detection:
  - sent_en is registered twice: en_d0, then en_d1.
  - en_flag = en_d0 & ~en_d1.
- Starting a frame:
  - When en_flag=1 and state is IDLE, on that edge: latch send_data, tx_busy<=1, txd<=0 (start bit), baud counter<=0, state<=START.
  - Latency: if sent_en rises before clock edge N, en_flag is high after edge N, and txd/tx_busy change at edge N+1.
- States: IDLE, START, DATA, [PARITY], STOP.
  - Baud counter counts 0..BPS_CNT-1 in every non-IDLE state.
  - At count BPS_CNT-1 the counter wraps to 0 and the bit advances.
- Transitions:
  - START -> DATA: txd<=data[0].
  - DATA: bits are sent in the order 0..7. After bit 7 the next state is PARITY (macro defined) or STOP; STOP drives txd<=1.
  - STOP at its last count: state<=IDLE, tx_busy<=0, tx_done<=1 for one cycle, txd stays 1.
- Timing:
  - Every bit is exactly BPS_CNT clocks long.
  - tx_busy is high for exactly 10*BPS_CNT clocks (11*BPS_CNT with parity).
- Requests while busy:
  - An en_flag while tx_busy=1 is ignored: no queueing, no restart, and the latched byte is not corrupted.
  - Changes on send_data mid-frame have no effect.
- Back-to-back frames:
  - An en_flag in the same cycle that STOP completes is ignored; state is still STOP on that edge.
  - An en_flag one cycle later (IDLE) is accepted. This gives a minimum inter-frame gap of 1 idle cycle at txd=1.
- Reset mid-frame: txd returns to 1 and tx_busy to 0 immediately, with no partial stop bit. The next sent_en rising edge after reset release starts a clean frame.
- Widths: the baud counter width is clog2(BPS_CNT); the bit index is 3 bits and never wraps past 7.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - txd = ^data XOR PARITY_ODD, held for BPS_CNT clocks.
  - Frame is 11 bits; tx_busy lasts 11*BPS_CNT clocks.
- Undefined:
  - No PARITY state or parity logic is present and PARITY_ODD is unused.
  - Frame is 10 bits.

Test Plan:
- CLK_FREQ=1_000_000, UART_BPS=100_000 (BPS_CNT=10); pulse sent_en high with send_data=8'hA5 -> txd=0 starts 2 edges after the rising edge of sent_en. txd then reads 1,0,1,0,0,1,0,1 at 10 clocks/bit, followed by a 10-clock stop bit=1. tx_busy is high for 100 clocks, then tx_done pulses once.
- Hold sent_en high continuously after sending 8'h3C -> exactly one frame is sent, and txd stays 1 after the stop bit.
- During a frame with 8'h55, raise sent_en again and change send_data=8'hFF at bit 3 -> the frame still carries 8'h55, no second frame follows, and tx_busy duration stays 100 clocks.
- Assert sys_rst for 1 cycle during bit 4 of 8'h81 -> txd=1 and tx_busy=0 immediately. A new sent_en edge with 8'h0F then yields a complete, correct frame.
- Two requests timed so the second edge lands 1 cycle after tx_done (8'h12 then 8'h34) -> both frames are sent, separated by exactly 1 idle cycle.
- With UART_TX_PARITY_EN and PARITY_ODD=0, send 8'h07 -> parity bit=1 and tx_busy lasts 110 clocks. With PARITY_ODD=1 -> parity bit=0.
